// File: rtl/bira_pkg.sv
// Shared definitions for the BIRA fault CAM collector and the spare allocation
// analyzer: field widths, packed CAM entry layouts with their bit positions,
// and the collector FSM / action encodings.
package bira_pkg;

    localparam int ROW_W   = 10;
    localparam int COL_W   = 10;
    localparam int IDX_W   = 5;   // pivot index field; limits a CAM to 32 entries
    localparam int CNT_W   = 3;
    localparam int PIV_W   = 26;
    localparam int NP_W    = 17;

    // Pivot entry bit positions
    localparam int PIV_VALID   = 25;
    localparam int PIV_ROW_LSB = 15;
    localparam int PIV_COL_LSB = 5;
    localparam int PIV_RMUST   = 4;
    localparam int PIV_CMUST   = 3;
    localparam int PIV_CNT_LSB = 0;

    // Non-pivot entry bit positions
    localparam int NP_VALID    = 16;
    localparam int NP_PIDX_LSB = 11;
    localparam int NP_DIR      = 10;
    localparam int NP_ADDR_LSB = 0;

    typedef struct packed {
        logic             valid;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic             row_must;
        logic             col_must;
        logic [CNT_W-1:0] cnt;
    } pivot_t;

    // addr holds the column when dir=0 (shares row), the row when dir=1
    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] pidx;
        logic             dir;
        logic [ROW_W-1:0] addr;
    } nonpivot_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MATCH,
        ST_WRITE
    } state_t;

    typedef enum logic [1:0] {
        ACT_DROP,
        ACT_PIVOT,
        ACT_NONPIV
    } act_t;

endpackage

// File: rtl/fault_cam_matcher.sv
// Combinational parallel compare of one (row, col) key against N CAM entries,
// with lowest-index priority encoders.
//   ent_valid/ent_row/ent_col : flattened entry fields (entry i at slice i)
//   key_row/key_col           : address being looked up
//   hit_row/idx_row           : some valid entry shares the row; lowest such index
//   hit_col/idx_col           : some valid entry shares the column; lowest such index
//   hit_exact                 : some valid entry equals the key on both fields
//   free_idx                  : lowest invalid entry (0 when the CAM is full)
module fault_cam_matcher
    import bira_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]       ent_valid,
    input  logic [N*ROW_W-1:0] ent_row,
    input  logic [N*COL_W-1:0] ent_col,
    input  logic [ROW_W-1:0]   key_row,
    input  logic [COL_W-1:0]   key_col,
    output logic               hit_row,
    output logic               hit_col,
    output logic               hit_exact,
    output logic [IDX_W-1:0]   idx_row,
    output logic [IDX_W-1:0]   idx_col,
    output logic [IDX_W-1:0]   free_idx
);

    always_comb begin
        logic r_m;
        logic c_m;
        r_m       = 1'b0;
        c_m       = 1'b0;
        hit_row   = 1'b0;
        hit_col   = 1'b0;
        hit_exact = 1'b0;
        idx_row   = '0;
        idx_col   = '0;
        free_idx  = '0;
        // Scan high to low so the last assignment is the lowest index
        for (int i = N - 1; i >= 0; i--) begin
            r_m = ent_valid[i] && (ent_row[i*ROW_W +: ROW_W] == key_row);
            c_m = ent_valid[i] && (ent_col[i*COL_W +: COL_W] == key_col);
            if (r_m) begin
                hit_row = 1'b1;
                idx_row = IDX_W'(i);
            end
            if (c_m) begin
                hit_col = 1'b1;
                idx_col = IDX_W'(i);
            end
            if (r_m && c_m) hit_exact = 1'b1;
            if (!ent_valid[i]) free_idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/fault_cam_collector.sv
// Collects BIST fault reports into pivot / non-pivot CAMs for spare allocation.
//   clk, rst        : clock, synchronous active-high reset
//   cam_clear       : one-cycle pulse, empties both CAMs and all flags
//   fault_valid/ready, fault_row/col : fault report handshake
//   pivot_cam       : PCAM packed pivot entries (26 bits each)
//   nonpivot_cam    : NPCAM packed non-pivot entries (17 bits each)
//   unrepairable    : sticky, set when a CAM would overflow
//   busy            : a report is being classified or written
// A report takes three cycles: IDLE (accept), MATCH (classify), WRITE (store).
// PCAM and NPCAM must not exceed 32 (5-bit pivot index).
module fault_cam_collector
    import bira_pkg::*;
#(
    parameter int PCAM    = 8,
    parameter int NPCAM   = 16,
    parameter int MUST_TH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cam_clear,
    input  logic                  fault_valid,
    output logic                  fault_ready,
    input  logic [ROW_W-1:0]      fault_row,
    input  logic [COL_W-1:0]      fault_col,
    output logic [PCAM*PIV_W-1:0] pivot_cam,
    output logic [NPCAM*NP_W-1:0] nonpivot_cam,
    output logic                  unrepairable,
    output logic                  busy
);

    state_t state, state_nxt;

    pivot_t    piv [PCAM];
    nonpivot_t npv [NPCAM];

    logic [ROW_W-1:0] key_row_p0;
    logic [COL_W-1:0] key_col_p0;
    act_t             act_p1, act_nxt;
    logic [IDX_W-1:0] pidx_p1, pidx_nxt;
    logic             dir_p1, dir_nxt;

    logic clr;
    assign clr = rst | cam_clear;

    function automatic logic [ROW_W-1:0] row_at(input logic [IDX_W-1:0] idx);
        logic [ROW_W-1:0] r;
        r = '0;
        for (int i = 0; i < PCAM; i++)
            if (IDX_W'(i) == idx) r = piv[i].row;
        return r;
    endfunction

    function automatic logic [COL_W-1:0] col_at(input logic [IDX_W-1:0] idx);
        logic [COL_W-1:0] c;
        c = '0;
        for (int i = 0; i < PCAM; i++)
            if (IDX_W'(i) == idx) c = piv[i].col;
        return c;
    endfunction

    function automatic logic must_at(input logic [IDX_W-1:0] idx, input logic dir);
        logic m;
        m = 1'b0;
        for (int i = 0; i < PCAM; i++)
            if (IDX_W'(i) == idx) m = dir ? piv[i].col_must : piv[i].row_must;
        return m;
    endfunction

    // Flatten pivots and rebuild each non-pivot's full (row, col) for the matchers
    logic [PCAM-1:0]        p_valid;
    logic [PCAM*ROW_W-1:0]  p_row;
    logic [PCAM*COL_W-1:0]  p_col;
    logic [NPCAM-1:0]       n_valid;
    logic [NPCAM*ROW_W-1:0] n_row;
    logic [NPCAM*COL_W-1:0] n_col;

    always_comb begin
        p_valid = '0;
        p_row   = '0;
        p_col   = '0;
        n_valid = '0;
        n_row   = '0;
        n_col   = '0;
        for (int i = 0; i < PCAM; i++) begin
            p_valid[i]               = piv[i].valid;
            p_row[i*ROW_W +: ROW_W]  = piv[i].row;
            p_col[i*COL_W +: COL_W]  = piv[i].col;
        end
        for (int j = 0; j < NPCAM; j++) begin
            n_valid[j] = npv[j].valid;
            if (npv[j].dir) begin
                n_row[j*ROW_W +: ROW_W] = npv[j].addr;
                n_col[j*COL_W +: COL_W] = col_at(npv[j].pidx);
            end else begin
                n_row[j*ROW_W +: ROW_W] = row_at(npv[j].pidx);
                n_col[j*COL_W +: COL_W] = npv[j].addr;
            end
        end
    end

    logic             p_hit_row, p_hit_col, p_exact;
    logic [IDX_W-1:0] p_idx_row, p_idx_col, p_free;
    logic             np_exact;
    logic [IDX_W-1:0] np_free;
    logic             unused_np_hit_row, unused_np_hit_col;
    logic [IDX_W-1:0] unused_np_idx_row, unused_np_idx_col;

    fault_cam_matcher #(.N(PCAM)) u_piv_match (
        .ent_valid (p_valid),
        .ent_row   (p_row),
        .ent_col   (p_col),
        .key_row   (key_row_p0),
        .key_col   (key_col_p0),
        .hit_row   (p_hit_row),
        .hit_col   (p_hit_col),
        .hit_exact (p_exact),
        .idx_row   (p_idx_row),
        .idx_col   (p_idx_col),
        .free_idx  (p_free)
    );

    fault_cam_matcher #(.N(NPCAM)) u_np_match (
        .ent_valid (n_valid),
        .ent_row   (n_row),
        .ent_col   (n_col),
        .key_row   (key_row_p0),
        .key_col   (key_col_p0),
        .hit_row   (unused_np_hit_row),
        .hit_col   (unused_np_hit_col),
        .hit_exact (np_exact),
        .idx_row   (unused_np_idx_row),
        .idx_col   (unused_np_idx_col),
        .free_idx  (np_free)
    );

    logic p_full, np_full;
    assign p_full  = &p_valid;
    assign np_full = &n_valid;

    // Classification; pivots never share a row or a column, so the lowest
    // row/column hit is the only one.
    always_comb begin
        logic covered;
        covered  = (p_hit_row && must_at(p_idx_row, 1'b0)) ||
                   (p_hit_col && must_at(p_idx_col, 1'b1));
        act_nxt  = ACT_DROP;
        pidx_nxt = p_idx_row;
        dir_nxt  = 1'b0;
        if (!unrepairable && !p_exact && !np_exact && !covered) begin
            if (p_hit_row) begin
                act_nxt = ACT_NONPIV;
            end else if (p_hit_col) begin
                act_nxt  = ACT_NONPIV;
                pidx_nxt = p_idx_col;
                dir_nxt  = 1'b1;
            end else begin
                act_nxt = ACT_PIVOT;
            end
        end
    end

    // Non-pivots already stored on the parent's line, excluding the new one
    int line_cnt;
    always_comb begin
        line_cnt = 0;
        for (int j = 0; j < NPCAM; j++)
            if (npv[j].valid && npv[j].pidx == pidx_p1 && npv[j].dir == dir_p1)
                line_cnt = line_cnt + 1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (fault_valid) state_nxt = ST_MATCH;
            ST_MATCH: state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= ST_IDLE;
            fault_ready <= 1'b1;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            fault_ready <= (state_nxt == ST_IDLE);
            busy        <= (state_nxt != ST_IDLE);
        end
    end

    // ---- stage p0: latch accepted report ----
    always_ff @(posedge clk) begin
        if (fault_ready && fault_valid) begin
            key_row_p0 <= fault_row;
            key_col_p0 <= fault_col;
        end
    end

    // ---- stage p1: register MATCH decision ----
    always_ff @(posedge clk) begin
        if (state == ST_MATCH) begin
            act_p1  <= act_nxt;
            pidx_p1 <= pidx_nxt;
            dir_p1  <= dir_nxt;
        end
    end

    // ---- WRITE: CAM update ----
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < PCAM; i++)  piv[i] <= '0;
            for (int j = 0; j < NPCAM; j++) npv[j] <= '0;
            unrepairable <= 1'b0;
        end else if (state == ST_WRITE) begin
            if (act_p1 == ACT_PIVOT) begin
                if (p_full) begin
                    unrepairable <= 1'b1;
                end else begin
                    for (int i = 0; i < PCAM; i++)
                        if (IDX_W'(i) == p_free)
                            piv[i] <= '{valid: 1'b1, row: key_row_p0, col: key_col_p0,
                                        row_must: 1'b0, col_must: 1'b0, cnt: '0};
                end
            end else if (act_p1 == ACT_NONPIV) begin
                if (np_full) begin
                    unrepairable <= 1'b1;
                end else begin
                    for (int j = 0; j < NPCAM; j++)
                        if (IDX_W'(j) == np_free)
                            npv[j] <= '{valid: 1'b1, pidx: pidx_p1, dir: dir_p1,
                                        addr: dir_p1 ? key_row_p0 : key_col_p0};
                    for (int i = 0; i < PCAM; i++) begin
                        if (IDX_W'(i) == pidx_p1) begin
                            if (piv[i].cnt != '1) piv[i].cnt <= piv[i].cnt + 1'b1;
                            if (line_cnt + 1 >= MUST_TH) begin
                                if (dir_p1) piv[i].col_must <= 1'b1;
                                else        piv[i].row_must <= 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < PCAM; g++) begin : g_piv_out
            assign pivot_cam[g*PIV_W +: PIV_W] = piv[g];
        end
        for (g = 0; g < NPCAM; g++) begin : g_np_out
            assign nonpivot_cam[g*NP_W +: NP_W] = npv[g];
        end
    endgenerate

endmodule

// File: tb/tb_fault_cam_collector.sv
module tb_fault_cam_collector;

    localparam int PCAM    = 8;
    localparam int NPCAM   = 16;
    localparam int MUST_TH = 2;

    logic                 clk;
    logic                 rst;
    logic                 cam_clear;
    logic                 fault_valid;
    logic                 fault_ready;
    logic [9:0]           fault_row;
    logic [9:0]           fault_col;
    logic [PCAM*26-1:0]   pivot_cam;
    logic [NPCAM*17-1:0]  nonpivot_cam;
    logic                 unrepairable;
    logic                 busy;

    fault_cam_collector #(.PCAM(PCAM), .NPCAM(NPCAM), .MUST_TH(MUST_TH)) dut (
        .clk          (clk),
        .rst          (rst),
        .cam_clear    (cam_clear),
        .fault_valid  (fault_valid),
        .fault_ready  (fault_ready),
        .fault_row    (fault_row),
        .fault_col    (fault_col),
        .pivot_cam    (pivot_cam),
        .nonpivot_cam (nonpivot_cam),
        .unrepairable (unrepairable),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: lists of pivots and non-pivots; entries are never
    // removed, so the lowest free slot is simply the current length.
    int m_prow[PCAM], m_pcol[PCAM], m_cnt[PCAM];
    bit m_rm[PCAM], m_cm[PCAM];
    int m_pn;
    int m_npidx[NPCAM], m_naddr[NPCAM];
    bit m_ndir[NPCAM];
    int m_nn;
    bit m_unrep;

    function automatic void model_clear();
        m_pn = 0; m_nn = 0; m_unrep = 0;
    endfunction

    function automatic void model_add_np(int p, bit d, int a);
        int k;
        if (m_nn == NPCAM) begin
            m_unrep = 1;
            return;
        end
        m_npidx[m_nn] = p; m_ndir[m_nn] = d; m_naddr[m_nn] = a;
        m_nn++;
        if (m_cnt[p] < 7) m_cnt[p]++;
        k = 0;
        for (int j = 0; j < m_nn; j++)
            if (m_npidx[j] == p && m_ndir[j] == d) k++;
        if (k >= MUST_TH) begin
            if (d) m_cm[p] = 1;
            else   m_rm[p] = 1;
        end
    endfunction

    function automatic void model_apply(int r, int c);
        int ri, cj, rr, cc;
        if (m_unrep) return;
        for (int i = 0; i < m_pn; i++)
            if (m_prow[i] == r && m_pcol[i] == c) return;
        for (int j = 0; j < m_nn; j++) begin
            rr = m_ndir[j] ? m_naddr[j] : m_prow[m_npidx[j]];
            cc = m_ndir[j] ? m_pcol[m_npidx[j]] : m_naddr[j];
            if (rr == r && cc == c) return;
        end
        ri = -1; cj = -1;
        for (int i = 0; i < m_pn; i++) begin
            if (ri < 0 && m_prow[i] == r) ri = i;
            if (cj < 0 && m_pcol[i] == c) cj = i;
        end
        if (ri >= 0 && m_rm[ri]) return;
        if (cj >= 0 && m_cm[cj]) return;
        if (ri >= 0)      model_add_np(ri, 1'b0, c);
        else if (cj >= 0) model_add_np(cj, 1'b1, r);
        else if (m_pn == PCAM) m_unrep = 1;
        else begin
            m_prow[m_pn] = r; m_pcol[m_pn] = c; m_cnt[m_pn] = 0;
            m_rm[m_pn] = 0; m_cm[m_pn] = 0;
            m_pn++;
        end
    endfunction

    function automatic logic [PCAM*26-1:0] exp_piv();
        logic [PCAM*26-1:0] v;
        v = '0;
        for (int i = 0; i < m_pn; i++)
            v[i*26 +: 26] = {1'b1, 10'(m_prow[i]), 10'(m_pcol[i]), m_rm[i], m_cm[i], 3'(m_cnt[i])};
        return v;
    endfunction

    function automatic logic [NPCAM*17-1:0] exp_np();
        logic [NPCAM*17-1:0] v;
        v = '0;
        for (int j = 0; j < m_nn; j++)
            v[j*17 +: 17] = {1'b1, 5'(m_npidx[j]), m_ndir[j], 10'(m_naddr[j])};
        return v;
    endfunction

    // Presents one report and returns half a cycle after it is accepted
    task automatic send(input int r, input int c);
        @(negedge clk);
        fault_row   = 10'(r);
        fault_col   = 10'(c);
        fault_valid = 1'b1;
        for (int k = 0; k < 20 && fault_ready !== 1'b1; k++) @(negedge clk);
        checks++;
        if (fault_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout ready=%b required 1", fault_ready);
            fault_valid = 1'b0;
        end else begin
            @(posedge clk);
            model_apply(r, c);
            @(negedge clk);
            fault_valid = 1'b0;
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        cam_clear = 1'b1;
        @(negedge clk);
        cam_clear = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        checks++;
        if (fault_ready !== 1'b1 || busy !== 1'b0 || unrepairable !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl ready=%b busy=%b unrep=%b required 1 0 0", fault_ready, busy, unrepairable);
        end
        checks++;
        if (pivot_cam !== '0 || nonpivot_cam !== '0) begin
            errors++;
            $display("FAIL reset_cam piv=%h np=%h required 0", pivot_cam, nonpivot_cam);
        end
    endtask

    task automatic test_basic();
        int rows[3] = '{5, 5, 7};
        int cols[3] = '{9, 20, 9};
        logic [PCAM*26-1:0]  old_p;
        logic [NPCAM*17-1:0] old_n;
        for (int n = 0; n < 3; n++) begin
            old_p = exp_piv();
            old_n = exp_np();
            send(rows[n], cols[n]);
            checks++;
            if (fault_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL basic_busy n=%0d ready=%b busy=%b required 0 1", n, fault_ready, busy);
            end
            @(negedge clk);
            checks++;
            if (pivot_cam !== old_p || nonpivot_cam !== old_n) begin
                errors++;
                $display("FAIL basic_early n=%0d piv=%h np=%h required %h %h", n, pivot_cam, nonpivot_cam, old_p, old_n);
            end
            @(negedge clk);
            checks++;
            if (pivot_cam !== exp_piv() || nonpivot_cam !== exp_np()) begin
                errors++;
                $display("FAIL basic_update n=%0d piv=%h np=%h required %h %h", n, pivot_cam, nonpivot_cam, exp_piv(), exp_np());
            end
        end
        checks++;
        if (pivot_cam[25:0] !== {1'b1, 10'd5, 10'd9, 1'b0, 1'b0, 3'd2}) begin
            errors++;
            $display("FAIL basic_pivot0 got=%h required %h", pivot_cam[25:0], {1'b1, 10'd5, 10'd9, 1'b0, 1'b0, 3'd2});
        end
        checks++;
        if (nonpivot_cam[33:0] !== {1'b1, 5'd0, 1'b1, 10'd7, 1'b1, 5'd0, 1'b0, 10'd20}) begin
            errors++;
            $display("FAIL basic_np01 got=%h required %h", nonpivot_cam[33:0], {1'b1, 5'd0, 1'b1, 10'd7, 1'b1, 5'd0, 1'b0, 10'd20});
        end
    endtask

    task automatic test_duplicate();
        logic [PCAM*26-1:0]  snap_p;
        logic [NPCAM*17-1:0] snap_n;
        snap_p = pivot_cam;
        snap_n = nonpivot_cam;
        send(5, 9);
        repeat (2) @(negedge clk);
        send(5, 20);
        repeat (2) @(negedge clk);
        checks++;
        if (pivot_cam !== snap_p || nonpivot_cam !== snap_n) begin
            errors++;
            $display("FAIL duplicate piv=%h np=%h required %h %h", pivot_cam, nonpivot_cam, snap_p, snap_n);
        end
    endtask

    task automatic test_must();
        int cols[4] = '{3, 10, 11, 12};
        pulse_clear();
        for (int n = 0; n < 4; n++) begin
            send(3, cols[n]);
            repeat (2) @(negedge clk);
            if (n == 2) begin
                checks++;
                if (pivot_cam[4] !== 1'b1) begin
                    errors++;
                    $display("FAIL must_set row_must=%b required 1", pivot_cam[4]);
                end
            end
        end
        checks++;
        if (pivot_cam[4:0] !== 5'b10010 || nonpivot_cam[2*17+16] !== 1'b0) begin
            errors++;
            $display("FAIL must_final flags_cnt=%b np2_valid=%b required 10010 0", pivot_cam[4:0], nonpivot_cam[2*17+16]);
        end
        checks++;
        if (pivot_cam !== exp_piv() || nonpivot_cam !== exp_np()) begin
            errors++;
            $display("FAIL must_model piv=%h np=%h required %h %h", pivot_cam, nonpivot_cam, exp_piv(), exp_np());
        end
    endtask

    task automatic test_overflow();
        logic [PCAM*26-1:0]  snap_p;
        logic [NPCAM*17-1:0] snap_n;
        pulse_clear();
        for (int k = 0; k < 8; k++) begin
            send(k, k + 100);
            repeat (2) @(negedge clk);
        end
        snap_p = pivot_cam;
        snap_n = nonpivot_cam;
        checks++;
        if (snap_p !== exp_piv() || unrepairable !== 1'b0) begin
            errors++;
            $display("FAIL overflow_fill piv=%h unrep=%b required %h 0", snap_p, unrepairable, exp_piv());
        end
        send(50, 500);
        repeat (2) @(negedge clk);
        checks++;
        if (unrepairable !== 1'b1 || pivot_cam !== snap_p || nonpivot_cam !== snap_n) begin
            errors++;
            $display("FAIL overflow_flag unrep=%b piv=%h required 1 %h", unrepairable, pivot_cam, snap_p);
        end
        send(1, 2);
        repeat (2) @(negedge clk);
        checks++;
        if (unrepairable !== 1'b1 || pivot_cam !== snap_p || nonpivot_cam !== snap_n) begin
            errors++;
            $display("FAIL overflow_frozen unrep=%b piv=%h required 1 %h", unrepairable, pivot_cam, snap_p);
        end
    endtask

    task automatic test_clear_in_match();
        send(40, 41);
        cam_clear = 1'b1;
        @(negedge clk);
        cam_clear = 1'b0;
        model_clear();
        checks++;
        if (pivot_cam !== '0 || nonpivot_cam !== '0 || fault_ready !== 1'b1 || unrepairable !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_match piv=%h np=%h ready=%b unrep=%b busy=%b required 0 0 1 0 0",
                     pivot_cam, nonpivot_cam, fault_ready, unrepairable, busy);
        end
        send(60, 61);
        repeat (2) @(negedge clk);
        checks++;
        if (pivot_cam[25:0] !== {1'b1, 10'd60, 10'd61, 5'd0} || pivot_cam !== exp_piv()) begin
            errors++;
            $display("FAIL clear_next_pivot got=%h required %h", pivot_cam, exp_piv());
        end
    endtask

    task automatic test_rst_mid();
        send(2, 3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        checks++;
        if (pivot_cam !== '0 || nonpivot_cam !== '0 || fault_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid piv=%h np=%h ready=%b busy=%b required 0 0 1 0", pivot_cam, nonpivot_cam, fault_ready, busy);
        end
    endtask

    task automatic test_back_to_back();
        int accepts;
        pulse_clear();
        accepts     = 0;
        fault_row   = 10'd20;
        fault_col   = 10'd30;
        fault_valid = 1'b1;
        for (int n = 0; n < 12; n++) begin
            if (n > 0) @(negedge clk);
            checks++;
            if (fault_ready !== ((n % 3) == 0)) begin
                errors++;
                $display("FAIL b2b_ready n=%0d ready=%b required %0d", n, fault_ready, (n % 3) == 0);
            end
            if (fault_ready === 1'b1) begin
                accepts++;
                model_apply(20, 30);
            end
        end
        fault_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (accepts != 4 || pivot_cam !== exp_piv() || nonpivot_cam !== exp_np()) begin
            errors++;
            $display("FAIL b2b_result accepts=%0d piv=%h required 4 %h", accepts, pivot_cam, exp_piv());
        end
    endtask

    task automatic test_random();
        int r, c;
        pulse_clear();
        for (int n = 0; n < 60; n++) begin
            if (n % 15 == 14) pulse_clear();
            r = $urandom_range(0, 5);
            c = $urandom_range(0, 5);
            send(r, c);
            repeat (2) @(negedge clk);
            checks++;
            if (pivot_cam !== exp_piv() || nonpivot_cam !== exp_np() || unrepairable !== m_unrep) begin
                errors++;
                $display("FAIL random n=%0d (%0d,%0d) piv=%h np=%h unrep=%b required %h %h %b",
                         n, r, c, pivot_cam, nonpivot_cam, unrepairable, exp_piv(), exp_np(), m_unrep);
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        cam_clear   = 1'b0;
        fault_valid = 1'b0;
        fault_row   = '0;
        fault_col   = '0;
        model_clear();
        test_reset();
        test_basic();
        test_duplicate();
        test_must();
        test_overflow();
        test_clear_in_match();
        test_rst_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
